// File: rtl/bg_writeback_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bg_writeback_packer                                           |
// | Purpose  : Packs 16-bit {variance, background} pairs into 32-bit memory  |
// |            words (two pairs per word), tags each word with its address   |
// |            within the frame and queues it in a small output FIFO.        |
// | Ports    : clk, rst (async, active-low)                                  |
// |            enable, wr_background, background_next[7:0],                  |
// |            variance_next[7:0], last_in_frame   -> pair input side        |
// |            in_ready                            <- pair can be accepted   |
// |            word_data[31:0], word_addr[ADDR_W-1:0], word_last,            |
// |            word_valid / word_ready             -> packed word stream     |
// |            frame_done  - one-cycle pulse after the last word is taken    |
// |            overflow    - sticky, a pair arrived while in_ready was low   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module bg_writeback_packer #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr_background,
  input  logic [7:0]        background_next,
  input  logic [7:0]        variance_next,
  input  logic              last_in_frame,
  output logic              in_ready,
  output logic [31:0]       word_data,
  output logic [ADDR_W-1:0] word_addr,
  output logic              word_last,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              frame_done,
  output logic              overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = 32 + ADDR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] C_LAST_IDX = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [15:0]       r_hold;
  logic [15:0]       w_hold_next;
  logic [ADDR_W-1:0] r_word_cnt;
  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_frame_done;
  logic              r_overflow;

  logic [15:0]       w_pair;
  logic              w_req;
  logic              w_accept;
  logic              w_drop;
  logic              w_push;
  logic [31:0]       w_push_word;
  logic              w_push_last;
  logic              w_pop;
  logic [ENT_W-1:0]  w_head;

  assign w_pair   = {variance_next, background_next};
  assign w_req    = enable && wr_background;
  // in_ready depends only on the occupancy register, so no input-to-output path.
  assign in_ready = (r_count < C_DEPTH);
  assign w_accept = w_req && in_ready;
  assign w_drop   = w_req && !in_ready;

  // Packer: next state, holding register and word push decision.
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold;
    w_push       = 1'b0;
    w_push_word  = 32'h0;
    w_push_last  = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          if (last_in_frame) begin
            // Odd-length frame: flush the lone pair in the low half.
            w_push      = 1'b1;
            w_push_word = {16'h0000, w_pair};
            w_push_last = 1'b1;
          end else begin
            w_hold_next  = w_pair;
            w_state_next = ST_HALF;
          end
        end
      end
      ST_HALF: begin
        if (w_accept) begin
          w_push       = 1'b1;
          w_push_word  = {w_pair, r_hold};
          w_push_last  = last_in_frame;
          w_state_next = ST_EMPTY;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_EMPTY;
      r_hold     <= 16'h0;
      r_word_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_hold  <= w_hold_next;
      if (w_push) begin
        // Counter wraps naturally at 2^ADDR_W; a frame end restarts it.
        r_word_cnt <= w_push_last ? '0 : r_word_cnt + 1'b1;
      end
    end
  end

  // FIFO storage needs no reset: the head is only visible while count != 0.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_push_last, r_word_cnt, w_push_word};
    end
  end

  assign w_pop = word_valid && word_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == C_LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == C_LAST_IDX) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_frame_done <= w_pop && word_last;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign word_valid = (r_count != '0);
  // Outputs forced to zero while empty so reset/idle values are clean.
  assign word_data  = word_valid ? w_head[31:0]          : 32'h0;
  assign word_addr  = word_valid ? w_head[ENT_W-2:32]    : '0;
  assign word_last  = word_valid ? w_head[ENT_W-1]       : 1'b0;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: doc/bg_writeback_packer.md
BG_WRITEBACK_PACKER -- requirements
Module: bg_writeback_packer

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the word address width.
REQ-002 Parameter FIFO_DEPTH, default 2, SHALL set the number of packed-word output FIFO entries (legal 2..8).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 Port enable  input  1  SHALL gate input acceptance; when low, inputs are ignored and the output side keeps draining.
REQ-006 Port wr_background  input  1  SHALL qualify one background/variance pair.
REQ-007 Port background_next  input  8  SHALL be the updated background pixel.
REQ-008 Port variance_next  input  8  SHALL be the updated variance.
REQ-009 Port last_in_frame  input  1  SHALL mark the qualified pair as the final pair of the frame.
REQ-010 Port in_ready  output  1  SHALL be high when a pair can be accepted.
REQ-011 Port word_data  output  32  SHALL carry the packed memory word.
REQ-012 Port word_addr  output  ADDR_W  SHALL carry the word address within the frame.
REQ-013 Port word_last  output  1  SHALL mark the final word of a frame.
REQ-014 Port word_valid  output  1  SHALL be high while the FIFO head holds a word.
REQ-015 Port word_ready  input  1  SHALL be the downstream acceptance signal.
REQ-016 Port frame_done  output  1  SHALL pulse for one cycle when a word_last word is accepted.
REQ-017 Port overflow  output  1  SHALL be a sticky flag for a pair dropped while in_ready was low.

Function
REQ-018 A pair SHALL be accepted when enable && wr_background && in_ready.
REQ-019 in_ready SHALL equal (fifo_count < FIFO_DEPTH), derived from registers only.
REQ-020 Pair format SHALL be {variance_next, background_next}, i.e. bits [15:8]=variance, [7:0]=background.
REQ-021 Packer states SHALL be EMPTY (no pair held) and HALF (pair0 held in a 16-bit holding register).
REQ-022 EMPTY + accepted pair, last_in_frame=0 -> store pair0, go to HALF; no word is produced.
REQ-023 HALF + accepted pair -> push word {pair1, pair0} (pair1 in [31:16]), go to EMPTY; word_last = last_in_frame.
REQ-024 EMPTY + accepted pair, last_in_frame=1 -> push word {16'h0000, pair0} with word_last=1 and stay in EMPTY (odd-length flush).
REQ-025 A pushed word SHALL appear at the FIFO head, with word_valid high, no earlier than the cycle after the completing pair is accepted.
REQ-026 word_addr SHALL be captured at push from a word counter that starts at 0, increments per push, and resets to 0 after a word_last push.
REQ-027 The word counter SHALL wrap modulo 2^ADDR_W without error.
REQ-028 A FIFO pop SHALL occur on word_valid && word_ready; a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-029 word_data, word_addr and word_last SHALL be held stable while word_valid && !word_ready.
REQ-030 FIFO entries SHALL be read in push order with no loss or duplication.
REQ-031 enable && wr_background && !in_ready SHALL drop the pair, leave the packer state unchanged, and set overflow.
REQ-032 frame_done SHALL be registered and assert the cycle after a pop of a word with word_last=1.
REQ-033 When enable is low, the packer state and holding register SHALL be held.

Reset
REQ-034 Asserting rst low SHALL immediately clear the state to EMPTY, set fifo_count=0, set the word counter to 0, and drive word_valid=0, frame_done=0, overflow=0, word_data=0, word_addr=0 and word_last=0.
REQ-035 Reset mid-frame SHALL discard the held pair and all queued words, with no word emitted after release.
REQ-036 After reset release, in_ready SHALL be high on the first clock edge.

Verification
REQ-037 Two pairs (bg=0x11,var=0x22), (bg=0x33,var=0x44) with word_ready=1 -> one word 0x44332211, addr 0, word_last=0.
REQ-038 Three pairs, the third with last_in_frame=1 -> words addr0 {p1,p0} and addr1 {0x0000,p2} with word_last=1; frame_done pulses once; next frame starts at addr 0.
REQ-039 word_ready=0 while 2*FIFO_DEPTH pairs are sent -> in_ready drops after FIFO_DEPTH words; one extra pair sets overflow; data is held stable; releasing word_ready drains words in order.
REQ-040 Steady state with word_ready=1 and a pair every cycle -> one word every 2 cycles, never stalls, overflow stays 0.
REQ-041 rst asserted while in HALF with 1 queued word -> word_valid=0 at once; after release, two new pairs yield a word at addr 0 containing only the new data.
REQ-042 ADDR_W=4 with 17 non-last words -> word_addr runs 0..15 then 0 (wrap).
